div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 144 ++++++++++++++
 tb/tb_div_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle restoring divider feeding a CDB: one shift-subtract step per cycle,
// sign correction on the final edge, result held until the bus grant arrives.
module div_unit #(
    parameter int WIDTH   = 32,
    parameter int LABEL_W = 4
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               EN,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   dataIn1,
    input  logic [WIDTH-1:0]   dataIn2,
    input  logic [LABEL_W-1:0] labelIn,
    output logic               available,
    output logic               require,
    input  logic               requireAC,
    output logic [WIDTH-1:0]   result,
    output logic [LABEL_W-1:0] labelOut
);

    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_rem;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dvz;
    logic [LABEL_W-1:0] r_label_in;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_result;
    logic [LABEL_W-1:0] r_label_out;

    logic               w_signed;
    logic               w_neg1;
    logic               w_neg2;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_steps_done;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;
    logic [WIDTH-1:0]   w_final;

    // Magnitudes of the issuing operands; the most negative value maps onto itself.
    assign w_signed = ~op[1];
    assign w_neg1   = w_signed & dataIn1[WIDTH-1];
    assign w_neg2   = w_signed & dataIn2[WIDTH-1];
    assign w_abs1   = w_neg1 ? -dataIn1 : dataIn1;
    assign w_abs2   = w_neg2 ? -dataIn2 : dataIn2;

    assign w_shift      = {r_rem, r_quo[WIDTH-1]};
    assign w_diff       = w_shift - {1'b0, r_dvs};
    assign w_steps_done = (r_cnt == CNT_W'(WIDTH));

    // A zero divisor leaves the dividend magnitude in r_rem, so the remainder
    // path reproduces dataIn1 without a separate bypass; only the quotient is forced.
    assign w_q_fix = r_dvz ? '1 : (r_neg_q ? -r_quo : r_quo);
    assign w_r_fix = r_neg_r ? -r_rem : r_rem;
    assign w_final = r_is_rem ? w_r_fix : w_q_fix;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (EN)           w_next = S_BUSY;
            S_BUSY: if (w_steps_done) w_next = S_DONE;
            S_DONE: if (requireAC)    w_next = S_IDLE;
            default:                  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_cnt       <= '0;
            r_is_rem    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dvz       <= 1'b0;
            r_label_in  <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_dvs       <= '0;
            r_result    <= '0;
            r_label_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (EN) begin
                        r_cnt      <= '0;
                        r_is_rem   <= op[0];
                        r_neg_q    <= w_neg1 ^ w_neg2;
                        r_neg_r    <= w_neg1;
                        r_dvz      <= (dataIn2 == '0);
                        r_label_in <= labelIn;
                        r_quo      <= w_abs1;
                        r_rem      <= '0;
                        r_dvs      <= w_abs2;
                    end
                end
                S_BUSY: begin
                    if (!w_steps_done) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (!w_diff[WIDTH]) begin
                            r_rem <= w_diff[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_result    <= w_final;
                        r_label_out <= r_label_in;
                    end
                end
                default: ;
            endcase
        end
    end

    assign available = (r_state == S_IDLE);
    assign require   = (r_state == S_DONE);
    assign result    = r_result;
    assign labelOut  = r_label_out;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, corner sequences
// (grant stall, tied grant, mid-operation reset) and randomized ops vs. a model.
module tb_div_unit;

    logic        clk;
    logic        nRST;
    logic        EN;
    logic [1:0]  op;
    logic [31:0] dataIn1;
    logic [31:0] dataIn2;
    logic [3:0]  labelIn;
    logic        available;
    logic        require;
    logic        requireAC;
    logic [31:0] result;
    logic [3:0]  labelOut;

    int n_vec = 0;
    int n_err = 0;

    div_unit #(.WIDTH(32), .LABEL_W(4)) dut (
        .clk       (clk),
        .nRST      (nRST),
        .EN        (EN),
        .op        (op),
        .dataIn1   (dataIn1),
        .dataIn2   (dataIn2),
        .labelIn   (labelIn),
        .available (available),
        .require   (require),
        .requireAC (requireAC),
        .result    (result),
        .labelOut  (labelOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  lab;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Truncating integer division with the divide-by-zero and overflow rules.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0) return o[0] ? a : 32'hFFFF_FFFF;
        if (o[1]) return o[0] ? (a % b) : (a / b);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[0] ? 32'd0 : 32'h8000_0000;
        sa = a;
        sb = b;
        return o[0] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    // Issue one op, wait for require, check latency/result/label, then grant.
    task automatic run_check(input string nm, input logic [1:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] lab,
                             input logic [31:0] exp, input int hold);
        int cyc;
        @(negedge clk);
        chk({nm, " avail_before"}, 32'(available), 32'd1);
        EN = 1'b1; op = o; dataIn1 = a; dataIn2 = b; labelIn = lab;
        @(posedge clk);
        #1;
        EN = 1'b0;
        cyc = 0;
        while (!require && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({nm, " latency"}, 32'(cyc), 32'd33);
        chk({nm, " result"}, result, exp);
        chk({nm, " label"}, 32'(labelOut), 32'(lab));
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        requireAC = 1'b1;
        @(posedge clk);
        #1;
        requireAC = 1'b0;
        chk({nm, " avail_after"}, {31'd0, available, require}, 32'd2);
    endtask

    initial begin
        int cyc;
        int hits;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rl;

        tbl[0]  = '{2'b00, 32'd100,        32'd7,          4'd3,  32'd14};
        tbl[1]  = '{2'b01, 32'hFFFF_FFF9,  32'd2,          4'd5,  32'hFFFF_FFFF};
        tbl[2]  = '{2'b11, 32'hFFFF_FFF9,  32'd2,          4'd6,  32'd1};
        tbl[3]  = '{2'b00, 32'd1234,       32'd0,          4'd7,  32'hFFFF_FFFF};
        tbl[4]  = '{2'b01, 32'd1234,       32'd0,          4'd8,  32'd1234};
        tbl[5]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  4'd9,  32'h8000_0000};
        tbl[6]  = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  4'd10, 32'd0};
        tbl[7]  = '{2'b10, 32'd1000,       32'd3,          4'd11, 32'd333};
        tbl[8]  = '{2'b11, 32'd1000,       32'd3,          4'd12, 32'd1};
        tbl[9]  = '{2'b00, 32'hFFFF_FF9C,  32'd7,          4'd13, 32'hFFFF_FFF2};
        tbl[10] = '{2'b01, 32'hFFFF_FF9C,  32'd7,          4'd14, 32'hFFFF_FFFE};
        tbl[11] = '{2'b01, 32'd100,        32'hFFFF_FFF9,  4'd15, 32'd2};
        tbl[12] = '{2'b10, 32'd5,          32'd0,          4'd1,  32'hFFFF_FFFF};
        tbl[13] = '{2'b01, 32'hFFFF_FFF0,  32'd0,          4'd2,  32'hFFFF_FFF0};

        nRST = 1'b1; EN = 1'b0; op = 2'b00; dataIn1 = '0; dataIn2 = '0;
        labelIn = '0; requireAC = 1'b0;
        #2 nRST = 1'b0;
        #1;
        chk("reset_outputs", {available, require, labelOut, result[25:0]}, {1'b1, 1'b0, 4'd0, 26'd0});
        chk("reset_result", result, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        nRST = 1'b1;

        foreach (tbl[i])
            run_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].lab, tbl[i].exp, i % 3);

        // Grant tied high throughout: completes and frees the unit one cycle later.
        requireAC = 1'b1;
        @(negedge clk);
        EN = 1'b1; op = 2'b00; dataIn1 = 32'd100; dataIn2 = 32'd7; labelIn = 4'd3;
        @(posedge clk);
        #1;
        EN = 1'b0;
        cyc = 0;
        while (!require && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("tied latency", 32'(cyc), 32'd33);
        chk("tied result", result, 32'd14);
        chk("tied label", 32'(labelOut), 32'd3);
        @(posedge clk);
        #1;
        chk("tied release", {31'd0, available, require}, 32'd2);
        requireAC = 1'b0;

        // Grant withheld 5 cycles while EN pulses with a different op.
        @(negedge clk);
        EN = 1'b1; op = 2'b00; dataIn1 = 32'd500; dataIn2 = 32'd7; labelIn = 4'd4;
        @(posedge clk);
        #1;
        EN = 1'b0;
        cyc = 0;
        while (!require && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("stall latency", 32'(cyc), 32'd33);
        for (int k = 0; k < 5; k++) begin
            EN = 1'b1; op = 2'b11; dataIn1 = 32'd9; dataIn2 = 32'd4; labelIn = 4'd9;
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d flags", k), {30'd0, require, available}, 32'd2);
            chk($sformatf("stall%0d result", k), result, 32'd71);
            chk($sformatf("stall%0d label", k), 32'(labelOut), 32'd4);
        end
        requireAC = 1'b1;
        @(posedge clk);
        #1;
        requireAC = 1'b0;
        EN = 1'b0;
        chk("stall grant", {31'd0, available, require}, 32'd2);
        chk("stall hold result", result, 32'd71);
        @(posedge clk);
        #1;
        chk("no accept at grant", 32'(available), 32'd1);

        // Reset partway through the iterations.
        @(negedge clk);
        EN = 1'b1; op = 2'b10; dataIn1 = 32'h1234_5678; dataIn2 = 32'd3; labelIn = 4'd8;
        @(posedge clk);
        #1;
        EN = 1'b0;
        repeat (10) @(posedge clk);
        #3 nRST = 1'b0;
        #1;
        chk("midreset flags", {30'd0, available, require}, 32'd2);
        chk("midreset result", result, 32'd0);
        chk("midreset label", 32'(labelOut), 32'd0);
        @(negedge clk);
        nRST = 1'b1;
        hits = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (require) hits++;
        end
        chk("no require after reset", 32'(hits), 32'd0);
        run_check("post_reset", 2'b00, 32'd50, 32'd5, 4'd6, 32'd10, 0);

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2, 3:    rb = 32'($urandom_range(1, 40));
                4:       rb = -32'($urandom_range(1, 40));
                default: rb = $urandom;
            endcase
            if (i % 9 == 4) ra = 32'h8000_0000;
            rl = 4'($urandom);
            run_check($sformatf("rnd%0d", i), ro, ra, rb, rl, model(ro, ra, rb), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
